// File: rtl/infs_pkg.sv
// Shared types and constants for the infs address router.
//   state_e    : router FSM states
//   ERR_DATA   : fill bit replicated across read data on error completions
//   ERR_CNT_W  : width of the saturating error counter
//   CNT_W      : width of the ack timeout counter (covers TIMEOUT up to 65535)
//   sat_inc    : saturating increment for the error counter
package infs_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAck = 2'd1,
        StDone    = 2'd2,
        StDrain   = 2'd3
    } state_e;

    localparam logic        ERR_DATA  = 1'b1;
    localparam int unsigned ERR_CNT_W = 8;
    localparam int unsigned CNT_W     = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
        return (val == '1) ? val : val + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/infs_addr_decode.sv
// Combinational window decoder for the infs address router.
//   addr_i   : address to decode
//   base_i   : packed window bases, channel k at [k*ADDR_W +: ADDR_W]
//   mask_i   : packed compare masks, 1 = bit compared
//   onehot_o : selected channel, at most one bit set (lowest matching window)
//   hit_o    : some window matched
//   offset_o : addr_i & ~mask of the selected window, zero on a miss
module infs_addr_decode #(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned N_CH   = 2
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [N_CH*ADDR_W-1:0] base_i,
    input  logic [N_CH*ADDR_W-1:0] mask_i,
    output logic [N_CH-1:0]        onehot_o,
    output logic                   hit_o,
    output logic [ADDR_W-1:0]      offset_o
);

    always_comb begin
        onehot_o = '0;
        hit_o    = 1'b0;
        offset_o = '0;
        // Scan downward so the lowest matching window overwrites any higher one.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (((addr_i ^ base_i[k*ADDR_W +: ADDR_W]) & mask_i[k*ADDR_W +: ADDR_W]) == '0) begin
                onehot_o    = '0;
                onehot_o[k] = 1'b1;
                hit_o       = 1'b1;
                offset_o    = addr_i & ~mask_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/infs_addr_router.sv
// Registered address router: one four-phase target port fanned out to N_CH
// initiator channels selected by programmable base/mask windows.
//   CLK, RST        : clock, synchronous active-high reset
//   T_S_EX_REQ      : target request (level, four-phase)
//   T_S_ADDR/CMD/D_WR : target address, command, write data
//   T_S_EX_ACK      : target ack; T_S_D_RD and T_S_ERR are valid while it is high
//   I_S_EX_REQ      : per-channel request, at most one bit set
//   I_S_ADDR        : latched window offset of the selected channel
//   I_S_CMD/D_WR    : latched command and write data, broadcast to all channels
//   I_S_EX_ACK      : per-channel ack
//   I_S_D_RD        : per-channel read data, channel k at [k*DATA_W +: DATA_W]
//   ERR_CNT         : saturating count of error completions (miss or timeout)
module infs_addr_router
    import infs_pkg::*;
#(
    parameter int unsigned            ADDR_W  = 40,
    parameter int unsigned            DATA_W  = 8,
    parameter int unsigned            CMD_W   = 3,
    parameter int unsigned            N_CH    = 2,
    parameter logic [N_CH*ADDR_W-1:0] CH_BASE = '0,
    parameter logic [N_CH*ADDR_W-1:0] CH_MASK = '1,
    parameter int unsigned            TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   T_S_EX_REQ,
    input  logic [ADDR_W-1:0]      T_S_ADDR,
    input  logic [CMD_W-1:0]       T_S_CMD,
    input  logic [DATA_W-1:0]      T_S_D_WR,
    output logic                   T_S_EX_ACK,
    output logic [DATA_W-1:0]      T_S_D_RD,
    output logic                   T_S_ERR,
    output logic [N_CH-1:0]        I_S_EX_REQ,
    output logic [ADDR_W-1:0]      I_S_ADDR,
    output logic [CMD_W-1:0]       I_S_CMD,
    output logic [DATA_W-1:0]      I_S_D_WR,
    input  logic [N_CH-1:0]        I_S_EX_ACK,
    input  logic [N_CH*DATA_W-1:0] I_S_D_RD,
    output logic [ERR_CNT_W-1:0]   ERR_CNT
);

    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ErrFill     = {DATA_W{ERR_DATA}};

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_CH-1:0]        sel_q, sel_d;
    logic [N_CH-1:0]        ireq_q, ireq_d;
    logic [ADDR_W-1:0]      iaddr_q, iaddr_d;
    logic [CMD_W-1:0]       icmd_q, icmd_d;
    logic [DATA_W-1:0]      iwr_q, iwr_d;
    logic                   tack_q, tack_d;
    logic [DATA_W-1:0]      trd_q, trd_d;
    logic                   terr_q, terr_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [N_CH-1:0]        dec_onehot;
    logic                   dec_hit;
    logic [ADDR_W-1:0]      dec_offset;
    logic [DATA_W-1:0]      sel_rd;
    logic                   sel_ack;
    logic                   err_entry;

    infs_addr_decode #(
        .ADDR_W (ADDR_W),
        .N_CH   (N_CH)
    ) u_decode (
        .addr_i   (T_S_ADDR),
        .base_i   (CH_BASE),
        .mask_i   (CH_MASK),
        .onehot_o (dec_onehot),
        .hit_o    (dec_hit),
        .offset_o (dec_offset)
    );

    // Only the latched channel's ack and read data are ever looked at.
    assign sel_ack = |(I_S_EX_ACK & sel_q);

    always_comb begin
        sel_rd = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_q[k]) begin
                sel_rd = sel_rd | I_S_D_RD[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        ireq_d    = ireq_q;
        iaddr_d   = iaddr_q;
        icmd_d    = icmd_q;
        iwr_d     = iwr_q;
        tack_d    = tack_q;
        trd_d     = trd_q;
        terr_d    = terr_q;
        err_cnt_d = err_cnt_q;
        err_entry = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (T_S_EX_REQ) begin
                    iaddr_d = dec_offset;
                    icmd_d  = T_S_CMD;
                    iwr_d   = T_S_D_WR;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        sel_d   = dec_onehot;
                        ireq_d  = dec_onehot;
                        state_d = StWaitAck;
                    end else begin
                        // Unmapped: complete straight away with an error.
                        sel_d     = '0;
                        tack_d    = 1'b1;
                        terr_d    = 1'b1;
                        trd_d     = ErrFill;
                        err_entry = 1'b1;
                        state_d   = StDone;
                    end
                end
            end

            StWaitAck: begin
                // Ack is checked first so it wins a tie with the timeout.
                if (sel_ack) begin
                    ireq_d  = '0;
                    tack_d  = 1'b1;
                    terr_d  = 1'b0;
                    trd_d   = sel_rd;
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    ireq_d    = '0;
                    tack_d    = 1'b1;
                    terr_d    = 1'b1;
                    trd_d     = ErrFill;
                    err_entry = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                if (!T_S_EX_REQ) begin
                    tack_d = 1'b0;
                    // Errored transactions never raised or lost their initiator
                    // handshake, so there is nothing to drain.
                    state_d = terr_q ? StIdle : StDrain;
                end
            end

            StDrain: begin
                if (!sel_ack) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (err_entry) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= '0;
            ireq_q    <= '0;
            iaddr_q   <= '0;
            icmd_q    <= '0;
            iwr_q     <= '0;
            tack_q    <= 1'b0;
            trd_q     <= '0;
            terr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            ireq_q    <= ireq_d;
            iaddr_q   <= iaddr_d;
            icmd_q    <= icmd_d;
            iwr_q     <= iwr_d;
            tack_q    <= tack_d;
            trd_q     <= trd_d;
            terr_q    <= terr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign T_S_EX_ACK = tack_q;
    assign T_S_D_RD   = trd_q;
    assign T_S_ERR    = terr_q;
    assign I_S_EX_REQ = ireq_q;
    assign I_S_ADDR   = iaddr_q;
    assign I_S_CMD    = icmd_q;
    assign I_S_D_WR   = iwr_q;
    assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_infs_addr_router.sv
module tb_infs_addr_router;

    localparam int unsigned ADDR_W  = 40;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CMD_W   = 3;
    localparam int unsigned N_CH    = 2;
    localparam int unsigned TIMEOUT = 4;

    localparam logic [ADDR_W-1:0] B0 = 40'h2F753998EE;
    localparam logic [ADDR_W-1:0] M0 = ~40'h1;
    localparam logic [ADDR_W-1:0] B1 = 40'h9B7D1AC5E0;
    localparam logic [ADDR_W-1:0] M1 = ~40'h1F;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic                   T_S_EX_REQ = 1'b0;
    logic [ADDR_W-1:0]      T_S_ADDR = '0;
    logic [CMD_W-1:0]       T_S_CMD = '0;
    logic [DATA_W-1:0]      T_S_D_WR = '0;
    logic                   T_S_EX_ACK;
    logic [DATA_W-1:0]      T_S_D_RD;
    logic                   T_S_ERR;
    logic [N_CH-1:0]        I_S_EX_REQ;
    logic [ADDR_W-1:0]      I_S_ADDR;
    logic [CMD_W-1:0]       I_S_CMD;
    logic [DATA_W-1:0]      I_S_D_WR;
    logic [N_CH-1:0]        I_S_EX_ACK = '0;
    logic [N_CH*DATA_W-1:0] I_S_D_RD = '0;
    logic [7:0]             ERR_CNT;

    // Second instance with overlapping windows: 0x00..0xFF and exactly 0x10.
    logic                   req2 = 1'b0;
    logic                   t2_ack;
    logic [DATA_W-1:0]      t2_rd;
    logic                   t2_err;
    logic [N_CH-1:0]        i2_req;
    logic [ADDR_W-1:0]      i2_addr;
    logic [CMD_W-1:0]       i2_cmd;
    logic [DATA_W-1:0]      i2_wr;
    logic [N_CH-1:0]        i2_ack = '0;
    logic [N_CH*DATA_W-1:0] i2_rd = '0;
    logic [7:0]             i2_err_cnt;

    int checks = 0;
    int errors = 0;
    int exp_err_cnt = 0;

    always #5 CLK = ~CLK;

    infs_addr_router #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CMD_W   (CMD_W),
        .N_CH    (N_CH),
        .CH_BASE ({B1, B0}),
        .CH_MASK ({M1, M0}),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .T_S_EX_REQ (T_S_EX_REQ),
        .T_S_ADDR   (T_S_ADDR),
        .T_S_CMD    (T_S_CMD),
        .T_S_D_WR   (T_S_D_WR),
        .T_S_EX_ACK (T_S_EX_ACK),
        .T_S_D_RD   (T_S_D_RD),
        .T_S_ERR    (T_S_ERR),
        .I_S_EX_REQ (I_S_EX_REQ),
        .I_S_ADDR   (I_S_ADDR),
        .I_S_CMD    (I_S_CMD),
        .I_S_D_WR   (I_S_D_WR),
        .I_S_EX_ACK (I_S_EX_ACK),
        .I_S_D_RD   (I_S_D_RD),
        .ERR_CNT    (ERR_CNT)
    );

    infs_addr_router #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CMD_W   (CMD_W),
        .N_CH    (N_CH),
        .CH_BASE ({40'h10, 40'h0}),
        .CH_MASK ({40'hFF_FFFF_FFFF, ~40'hFF}),
        .TIMEOUT (255)
    ) dut_ovl (
        .CLK        (CLK),
        .RST        (RST),
        .T_S_EX_REQ (req2),
        .T_S_ADDR   (T_S_ADDR),
        .T_S_CMD    (T_S_CMD),
        .T_S_D_WR   (T_S_D_WR),
        .T_S_EX_ACK (t2_ack),
        .T_S_D_RD   (t2_rd),
        .T_S_ERR    (t2_err),
        .I_S_EX_REQ (i2_req),
        .I_S_ADDR   (i2_addr),
        .I_S_CMD    (i2_cmd),
        .I_S_D_WR   (i2_wr),
        .I_S_EX_ACK (i2_ack),
        .I_S_D_RD   (i2_rd),
        .ERR_CNT    (i2_err_cnt)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference window lookup: first window whose compared bits equal the base.
    function automatic int ref_chan(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] b [2];
        logic [ADDR_W-1:0] m [2];
        b[0] = B0; m[0] = M0;
        b[1] = B1; m[1] = M1;
        for (int k = 0; k < 2; k++) begin
            if ((a & m[k]) == (b[k] & m[k])) return k;
        end
        return -1;
    endfunction

    function automatic logic [ADDR_W-1:0] ref_offset(input logic [ADDR_W-1:0] a, input int ch);
        return (ch == 0) ? (a & ~M0) : (a & ~M1);
    endfunction

    // One full four-phase transaction. dly = cycles the initiator waits after
    // seeing its request before acking (-1 = never). late_ack raises the
    // selected ack after an error completion, which must be ignored.
    task automatic do_txn(input logic [ADDR_W-1:0] a, input int dly,
                          input logic [DATA_W-1:0] rdata, input bit late_ack);
        int                ch;
        int                hi;
        int                exp_hi;
        bit                exp_err;
        logic [DATA_W-1:0] exp_rd;
        logic [CMD_W-1:0]  c;
        logic [DATA_W-1:0] w;
        logic [N_CH-1:0]   sel;
        logic [ADDR_W-1:0] off;

        ch  = ref_chan(a);
        c   = CMD_W'($urandom);
        w   = DATA_W'($urandom);
        sel = (ch == 0) ? 2'b01 : ((ch == 1) ? 2'b10 : 2'b00);
        off = ref_offset(a, ch);

        T_S_ADDR   = a;
        T_S_CMD    = c;
        T_S_D_WR   = w;
        T_S_EX_REQ = 1'b1;
        I_S_D_RD   = 16'($urandom);
        tick();

        if (ch < 0) begin
            check("miss_no_req", 64'(I_S_EX_REQ), 64'd0);
            exp_err = 1'b1;
            exp_rd  = 8'hFF;
        end else begin
            check("req_onehot", 64'(I_S_EX_REQ), 64'(sel));
            check("req_offset", 64'(I_S_ADDR), 64'(off));
            check("req_cmd", 64'(I_S_CMD), 64'(c));
            check("req_wdata", 64'(I_S_D_WR), 64'(w));
            check("ack_not_yet", 64'(T_S_EX_ACK), 64'd0);
            exp_err = !(dly >= 0 && dly + 1 <= int'(TIMEOUT));
            exp_hi  = exp_err ? int'(TIMEOUT) : dly + 1;
            exp_rd  = exp_err ? 8'hFF : rdata;
            hi = 0;
            for (int i = 0; i < 64; i++) begin
                if (I_S_EX_REQ == '0) break;
                hi++;
                // Noise on the other channel must never be taken as an ack.
                I_S_EX_ACK = 2'($urandom) & ~sel;
                if (dly >= 0 && i == dly) begin
                    I_S_EX_ACK = I_S_EX_ACK | sel;
                    I_S_D_RD   = (ch == 0) ? {8'($urandom), rdata} : {rdata, 8'($urandom)};
                end
                tick();
            end
            check("req_cycles", 64'(hi), 64'(exp_hi));
        end

        if (exp_err) exp_err_cnt = (exp_err_cnt == 255) ? 255 : exp_err_cnt + 1;
        check("done_ack", 64'(T_S_EX_ACK), 64'd1);
        check("done_err", 64'(T_S_ERR), 64'(exp_err));
        check("done_rdata", 64'(T_S_D_RD), 64'(exp_rd));
        check("done_req_clr", 64'(I_S_EX_REQ), 64'd0);
        check("err_cnt", 64'(ERR_CNT), 64'(exp_err_cnt));

        // Hold the target request a little; ack and data must stay put.
        repeat ($urandom_range(0, 2)) begin
            if (exp_err) I_S_EX_ACK = (late_ack ? sel : 2'b00) | (2'($urandom) & ~sel);
            else         I_S_EX_ACK = sel | (2'($urandom) & ~sel);
            tick();
        end
        if (exp_err && late_ack) I_S_EX_ACK = I_S_EX_ACK | sel;
        check("hold_ack", 64'(T_S_EX_ACK), 64'd1);
        check("hold_rdata", 64'(T_S_D_RD), 64'(exp_rd));

        T_S_EX_REQ = 1'b0;
        tick();
        check("ack_fall", 64'(T_S_EX_ACK), 64'd0);
        if (ch >= 0) check("offset_stable", 64'(I_S_ADDR), 64'(off));

        repeat ($urandom_range(0, 2)) tick();
        I_S_EX_ACK = '0;
        tick();
        check("idle_req", 64'(I_S_EX_REQ), 64'd0);
        check("idle_ack", 64'(T_S_EX_ACK), 64'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        int                dly;
        int                r;

        // Reset values
        tick();
        tick();
        check("rst_ack", 64'(T_S_EX_ACK), 64'd0);
        check("rst_rd", 64'(T_S_D_RD), 64'd0);
        check("rst_err", 64'(T_S_ERR), 64'd0);
        check("rst_ireq", 64'(I_S_EX_REQ), 64'd0);
        check("rst_iaddr", 64'(I_S_ADDR), 64'd0);
        check("rst_icmd", 64'(I_S_CMD), 64'd0);
        check("rst_iwr", 64'(I_S_D_WR), 64'd0);
        check("rst_errcnt", 64'(ERR_CNT), 64'd0);
        RST = 1'b0;
        tick();

        // Directed: ack on the timeout edge wins, channel 1 read, miss, timeout + late ack
        do_txn(40'h2F753998EF, 3, 8'h3C, 1'b0);
        do_txn(40'h9B7D1AC5F3, 0, 8'hA5, 1'b0);
        do_txn(40'h0000000000, 0, 8'h00, 1'b0);
        do_txn(B0, -1, 8'h11, 1'b1);
        do_txn(B1, 4, 8'h22, 1'b1);

        // Overlapping windows: only the lower channel is requested
        T_S_ADDR = 40'h10;
        req2     = 1'b1;
        tick();
        check("ovl_req", 64'(i2_req), 64'h1);
        check("ovl_off", 64'(i2_addr), 64'h10);
        i2_ack = 2'b01;
        i2_rd  = 16'h3C5A;
        tick();
        check("ovl_ack", 64'(t2_ack), 64'd1);
        check("ovl_rd", 64'(t2_rd), 64'h5A);
        check("ovl_err", 64'(t2_err), 64'd0);
        req2 = 1'b0;
        tick();
        i2_ack = '0;
        tick();
        check("ovl_idle", 64'(t2_ack), 64'd0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      a = B0 ^ 40'($urandom_range(0, 1));
            else if (r < 8) a = B1 | 40'($urandom_range(0, 31));
            else            a = {8'($urandom), 32'($urandom)};
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
            do_txn(a, dly, 8'($urandom), 1'($urandom));
        end

        // Reset in the middle of a wait for ack
        T_S_ADDR   = B0;
        T_S_EX_REQ = 1'b1;
        I_S_EX_ACK = '0;
        tick();
        check("pre_rst_req", 64'(I_S_EX_REQ), 64'h1);
        tick();
        RST        = 1'b1;
        T_S_EX_REQ = 1'b0;
        tick();
        check("mid_rst_ack", 64'(T_S_EX_ACK), 64'd0);
        check("mid_rst_rd", 64'(T_S_D_RD), 64'd0);
        check("mid_rst_err", 64'(T_S_ERR), 64'd0);
        check("mid_rst_ireq", 64'(I_S_EX_REQ), 64'd0);
        check("mid_rst_iaddr", 64'(I_S_ADDR), 64'd0);
        check("mid_rst_icmd", 64'(I_S_CMD), 64'd0);
        check("mid_rst_iwr", 64'(I_S_D_WR), 64'd0);
        check("mid_rst_errcnt", 64'(ERR_CNT), 64'd0);
        RST         = 1'b0;
        exp_err_cnt = 0;
        tick();
        do_txn(B1 | 40'h5, 1, 8'h77, 1'b0);

        // Error counter saturation
        T_S_ADDR = '0;
        for (int n = 0; n < 260; n++) begin
            T_S_EX_REQ = 1'b1;
            tick();
            exp_err_cnt = (exp_err_cnt == 255) ? 255 : exp_err_cnt + 1;
            check("sat_cnt", 64'(ERR_CNT), 64'(exp_err_cnt));
            T_S_EX_REQ = 1'b0;
            tick();
        end
        check("sat_final", 64'(ERR_CNT), 64'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
